// File: rtl/top_debug_mips.sv
// -----------------------------------------------------------------------------
// top_debug_mips
//   UART-byte-driven debug wrapper around a minimal 32-bit core.
//   Commands arrive as received bytes. The wrapper can:
//     - load the 256-byte instruction memory,
//     - run the core until it halts,
//     - single-step the core,
//     - dump PC, cycle count, register bank and data memory as a TX byte stream.
//
// Ports
//   i_clock        system clock, rising edge
//   i_reset        synchronous reset, active low (has priority over the freeze)
//   i_clock_reset  freeze: while high every register, including pulses, holds
//   i_rx_done      1-cycle strobe, i_rx_data valid
//   i_rx_data      received byte
//   i_tx_done      1-cycle strobe, UART finished the previous byte
//   o_tx_data      byte to send, valid with o_tx_start
//   o_tx_start     1-cycle transmit request
//   o_halt         core hit HALT or ran past the end of instruction memory
//   o_state        one-hot FSM state
// -----------------------------------------------------------------------------
module top_debug_mips #(
  parameter int BYTE    = 8,
  parameter int DWORD   = 32,
  parameter int ADDR    = 5,
  parameter int RB_ADDR = 5,
  parameter int NB_ST   = 10
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_clock_reset,
  input  logic             i_rx_done,
  input  logic [BYTE-1:0]  i_rx_data,
  input  logic             i_tx_done,
  output logic [BYTE-1:0]  o_tx_data,
  output logic             o_tx_start,
  output logic             o_halt,
  output logic [NB_ST-1:0] o_state
);

  localparam int IM_DEPTH = 256;
  localparam int NREG     = 2 ** RB_ADDR;
  localparam int NMEM     = 2 ** ADDR;

  localparam logic [BYTE-1:0] CMD_LOAD = BYTE'(8'h01);
  localparam logic [BYTE-1:0] CMD_RUN  = BYTE'(8'h02);
  localparam logic [BYTE-1:0] CMD_STEP = BYTE'(8'h03);
  localparam logic [BYTE-1:0] CMD_NEXT = BYTE'(8'h04);
  localparam logic [BYTE-1:0] CMD_EXIT = BYTE'(8'h05);

  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_HALT = 6'b111111;

  typedef enum logic [NB_ST-1:0] {
    S_IDLE      = NB_ST'(1),
    S_LOAD      = NB_ST'(2),
    S_RUN       = NB_ST'(4),
    S_STEP_WAIT = NB_ST'(8),
    S_STEP      = NB_ST'(16),
    S_TX_PC     = NB_ST'(32),
    S_TX_CYC    = NB_ST'(64),
    S_TX_REG    = NB_ST'(128),
    S_TX_MEM    = NB_ST'(256),
    S_TX_WAIT   = NB_ST'(512)
  } state_t;

  state_t              state_q;
  state_t              sec_q;      // dump section to return to after TX_WAIT
  logic [7:0]          ptr_q;
  logic [DWORD-1:0]    pc_q;
  logic [DWORD-1:0]    cyc_q;
  logic                halt_q;
  logic                tx_start_q;
  logic [BYTE-1:0]     tx_data_q;
  logic [RB_ADDR-1:0]  word_q;     // register / data-memory word being dumped
  logic [1:0]          byte_q;     // byte within the word, 0 = MSB

  logic [BYTE-1:0]     im_q   [IM_DEPTH];
  logic [DWORD-1:0]    regs_q [NREG];
  logic [DWORD-1:0]    dmem_q [NMEM];

  // Fetch and decode of the instruction at PC
  logic [DWORD-1:0]    instr_d;
  logic [5:0]          op_d;
  logic [RB_ADDR-1:0]  rs_d;
  logic [RB_ADDR-1:0]  rt_d;
  logic [DWORD-1:0]    simm_d;
  logic [DWORD-1:0]    sum_d;
  logic [DWORD-1:0]    pc_next_d;
  logic [DWORD-1:0]    dump_word_d;
  logic [BYTE-1:0]     dump_byte_d;
  logic                im_we_d;

  function automatic logic [BYTE-1:0] pick_byte(input logic [DWORD-1:0] w,
                                                input logic [1:0] sel);
    case (sel)
      2'd0:    return w[4*BYTE-1 -: BYTE];
      2'd1:    return w[3*BYTE-1 -: BYTE];
      2'd2:    return w[2*BYTE-1 -: BYTE];
      default: return w[BYTE-1 -: BYTE];
    endcase
  endfunction

  always_comb begin
    instr_d   = {im_q[pc_q[7:0]], im_q[pc_q[7:0] + 8'd1],
                 im_q[pc_q[7:0] + 8'd2], im_q[pc_q[7:0] + 8'd3]};
    op_d      = instr_d[31:26];
    rs_d      = instr_d[21 +: RB_ADDR];
    rt_d      = instr_d[16 +: RB_ADDR];
    simm_d    = {{(DWORD-16){instr_d[15]}}, instr_d[15:0]};
    sum_d     = regs_q[rs_d] + simm_d;
    pc_next_d = pc_q + DWORD'(4);
  end

  // The current TX state names the section, so it also selects the word.
  always_comb begin
    case (state_q)
      S_TX_PC:  dump_word_d = pc_q;
      S_TX_CYC: dump_word_d = cyc_q;
      S_TX_REG: dump_word_d = regs_q[word_q];
      S_TX_MEM: dump_word_d = dmem_q[word_q[ADDR-1:0]];
      default:  dump_word_d = '0;
    endcase
    dump_byte_d = pick_byte(dump_word_d, byte_q);
  end

  assign im_we_d = i_reset && !i_clock_reset && (state_q == S_LOAD) && i_rx_done;

  // Instruction memory survives reset; only LOAD writes it.
  always_ff @(posedge i_clock) begin
    if (im_we_d) im_q[ptr_q] <= i_rx_data;
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state_q    <= S_IDLE;
      sec_q      <= S_TX_PC;
      ptr_q      <= '0;
      pc_q       <= '0;
      cyc_q      <= '0;
      halt_q     <= 1'b0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      word_q     <= '0;
      byte_q     <= '0;
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      for (int i = 0; i < NMEM; i++) dmem_q[i] <= '0;
    end else if (!i_clock_reset) begin
      tx_start_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (i_rx_done) begin
            if (i_rx_data == CMD_LOAD) begin
              ptr_q   <= '0;
              state_q <= S_LOAD;
            end else if (i_rx_data == CMD_RUN || i_rx_data == CMD_STEP) begin
              pc_q    <= '0;
              cyc_q   <= '0;
              halt_q  <= 1'b0;
              word_q  <= '0;
              byte_q  <= '0;
              for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
              for (int i = 0; i < NMEM; i++) dmem_q[i] <= '0;
              state_q <= (i_rx_data == CMD_RUN) ? S_RUN : S_STEP_WAIT;
            end
          end
        end

        S_LOAD: begin
          if (i_rx_done) begin
            ptr_q <= ptr_q + 8'd1;
            if (ptr_q == 8'hFF) state_q <= S_IDLE;
          end
        end

        S_RUN, S_STEP: begin
          cyc_q <= cyc_q + DWORD'(1);
          if (op_d == OP_HALT) begin
            halt_q  <= 1'b1;
            state_q <= S_TX_PC;
          end else begin
            if (op_d == OP_ADDI && rt_d != '0) regs_q[rt_d] <= sum_d;
            if (op_d == OP_SW) dmem_q[sum_d[ADDR-1:0]] <= regs_q[rt_d];
            pc_q <= pc_next_d;
            // Leaving the last word of memory counts as a halt.
            if (pc_next_d == DWORD'(IM_DEPTH)) begin
              halt_q  <= 1'b1;
              state_q <= S_TX_PC;
            end else if (state_q == S_STEP) begin
              state_q <= S_TX_PC;
            end
          end
        end

        S_STEP_WAIT: begin
          if (i_rx_done) begin
            if (i_rx_data == CMD_NEXT) state_q <= halt_q ? S_TX_PC : S_STEP;
            else if (i_rx_data == CMD_EXIT) state_q <= S_IDLE;
          end
        end

        S_TX_PC, S_TX_CYC, S_TX_REG, S_TX_MEM: begin
          tx_start_q <= 1'b1;
          tx_data_q  <= dump_byte_d;
          sec_q      <= state_q;
          state_q    <= S_TX_WAIT;
        end

        S_TX_WAIT: begin
          if (i_tx_done) begin
            if (byte_q != 2'd3) begin
              byte_q  <= byte_q + 2'd1;
              state_q <= sec_q;
            end else begin
              byte_q <= '0;
              case (sec_q)
                S_TX_PC:  state_q <= S_TX_CYC;
                S_TX_CYC: begin
                  word_q  <= '0;
                  state_q <= S_TX_REG;
                end
                S_TX_REG: begin
                  if (&word_q) begin
                    word_q  <= '0;
                    state_q <= S_TX_MEM;
                  end else begin
                    word_q  <= word_q + RB_ADDR'(1);
                    state_q <= S_TX_REG;
                  end
                end
                default: begin
                  if (&word_q[ADDR-1:0]) begin
                    word_q  <= '0;
                    state_q <= halt_q ? S_IDLE : S_STEP_WAIT;
                  end else begin
                    word_q  <= word_q + RB_ADDR'(1);
                    state_q <= S_TX_MEM;
                  end
                end
              endcase
            end
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_tx_data  = tx_data_q;
  assign o_tx_start = tx_start_q;
  assign o_halt     = halt_q;
  assign o_state    = state_q;

endmodule

// File: tb/tb_top_debug_mips.sv
module tb_top_debug_mips;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clk_rst = 1'b0;
  logic       rx_done = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       tx_done = 1'b0;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       halt;
  logic [9:0] state;

  always #5 clk = ~clk;

  top_debug_mips dut (
    .i_clock       (clk),
    .i_reset       (rst_n),
    .i_clock_reset (clk_rst),
    .i_rx_done     (rx_done),
    .i_rx_data     (rx_data),
    .i_tx_done     (tx_done),
    .o_tx_data     (tx_data),
    .o_tx_start    (tx_start),
    .o_halt        (halt),
    .o_state       (state)
  );

  localparam logic [9:0] ST_IDLE = 10'h001;
  localparam logic [9:0] ST_LOAD = 10'h002;
  localparam logic [9:0] ST_SW   = 10'h008;

  int tests = 0;
  int fails = 0;

  // Reference model: architectural state only
  logic [7:0]  m_im   [256];
  logic [31:0] m_regs [32];
  logic [31:0] m_dmem [32];
  int          m_pc;
  logic [31:0] m_cyc;
  bit          m_halt;

  logic [31:0] prog [64];
  logic [7:0]  got  [264];
  int          got_n;
  int          extra;

  typedef struct { logic [7:0] rx; logic [9:0] st; } vec_t;
  vec_t vt [8];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic void m_clear();
    m_pc = 0; m_cyc = 0; m_halt = 0;
    for (int i = 0; i < 32; i++) begin m_regs[i] = 0; m_dmem[i] = 0; end
  endfunction

  function automatic void m_step();
    logic [31:0] w, simm, ea;
    logic [5:0]  op;
    int rs, rt;
    if (m_pc >= 256) begin m_halt = 1; return; end
    w    = {m_im[m_pc], m_im[m_pc+1], m_im[m_pc+2], m_im[m_pc+3]};
    op   = w[31:26];
    rs   = int'(w[25:21]);
    rt   = int'(w[20:16]);
    simm = 32'($signed(w[15:0]));
    m_cyc = m_cyc + 1;
    if (op == 6'h3F) begin m_halt = 1; return; end
    ea = m_regs[rs] + simm;
    if (op == 6'h08) begin
      if (rt != 0) m_regs[rt] = ea;
    end else if (op == 6'h2B) begin
      m_dmem[ea[4:0]] = m_regs[rt];
    end
    m_pc += 4;
    if (m_pc == 256) m_halt = 1;
  endfunction

  function automatic logic [31:0] m_word(input int k);
    if (k == 0) return 32'(m_pc);
    if (k == 1) return m_cyc;
    if (k < 34) return m_regs[k-2];
    return m_dmem[k-34];
  endfunction

  function automatic logic [31:0] got_word(input int k);
    return {got[4*k], got[4*k+1], got[4*k+2], got[4*k+3]};
  endfunction

  function automatic logic [31:0] rand_instr();
    int r;
    logic [5:0] op;
    logic [4:0] rs, rt;
    logic [15:0] imm;
    r   = $urandom_range(0, 9);
    rs  = 5'($urandom_range(0, 7));
    rt  = 5'($urandom_range(0, 7));
    imm = 16'($urandom);
    if (r < 5)      op = 6'h08;
    else if (r < 8) op = 6'h2B;
    else begin
      op = 6'($urandom);
      if (op == 6'h08 || op == 6'h2B || op == 6'h3F) op = 6'h00;
    end
    return {op, rs, rt, imm};
  endfunction

  // All stimulus tasks start and end just after a falling edge.
  task automatic send_rx(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [7:0] prog_byte(input int i);
    logic [31:0] w;
    w = prog[i/4];
    return w[8*(3 - i%4) +: 8];
  endfunction

  task automatic load_prog(input string nm);
    send_rx(8'h01);
    for (int i = 0; i < 256; i++) begin
      send_rx(prog_byte(i));
      m_im[i] = prog_byte(i);
      if (i == 254) check({nm, "_state_load"}, 32'(state), 32'(ST_LOAD));
    end
    check({nm, "_state_idle"}, 32'(state), 32'(ST_IDLE));
  endtask

  // Collects one 264-byte dump, answering each byte with i_tx_done.
  task automatic capture_dump(input int dmin, input int dmax,
                              input int inject_at, input int freeze_at);
    int to, dly;
    got_n = 0;
    extra = 0;
    for (int b = 0; b < 264; b++) begin
      to = 0;
      while (!tx_start && to < 2000) begin @(negedge clk); to++; end
      if (!tx_start) begin
        tests++; fails++;
        $display("FAIL dump_timeout: got %0d bytes expected 264", got_n);
        return;
      end
      got[b] = tx_data;
      got_n++;
      if (b == freeze_at) begin
        clk_rst = 1'b1;
        for (int f = 0; f < 3; f++) begin
          @(negedge clk);
          check("freeze_start_held", 32'(tx_start), 32'd1);
          check("freeze_data_held", 32'(tx_data), 32'(got[b]));
        end
        clk_rst = 1'b0;
      end
      dly = $urandom_range(dmin, dmax);
      @(negedge clk);
      if (tx_start) extra++;
      for (int d = 1; d < dly; d++) begin
        @(negedge clk);
        if (tx_start) extra++;
      end
      tx_done = 1'b1;
      if (b == inject_at) begin rx_done = 1'b1; rx_data = 8'h01; end
      @(negedge clk);
      tx_done = 1'b0;
      rx_done = 1'b0;
    end
    for (int d = 0; d < 10; d++) begin
      @(negedge clk);
      if (tx_start) extra++;
    end
  endtask

  task automatic check_dump(input string nm);
    check({nm, "_pulses"}, 32'(got_n), 32'd264);
    check({nm, "_extra_pulses"}, 32'(extra), 32'd0);
    if (got_n == 264)
      for (int k = 0; k < 66; k++) check($sformatf("%s_word%0d", nm, k), got_word(k), m_word(k));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, to;
    vt[0] = '{8'h07, ST_IDLE};
    vt[1] = '{8'h00, ST_IDLE};
    vt[2] = '{8'h04, ST_IDLE};
    vt[3] = '{8'h05, ST_IDLE};
    vt[4] = '{8'h03, ST_SW};
    vt[5] = '{8'h01, ST_SW};
    vt[6] = '{8'h02, ST_SW};
    vt[7] = '{8'h05, ST_IDLE};

    @(negedge clk);
    do_reset();
    check("rst_state", 32'(state), 32'(ST_IDLE));
    check("rst_halt", 32'(halt), 32'd0);
    check("rst_tx_start", 32'(tx_start), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin @(negedge clk); if (tx_start) cnt++; end
    check("idle_no_tx", 32'(cnt), 32'd0);

    // Directed program: ADDI r1,r0,5 ; HALT ; NOPs
    for (int i = 0; i < 64; i++) prog[i] = 32'h0;
    prog[0] = 32'h20010005;
    prog[1] = 32'hFC000000;
    load_prog("load_dir");

    for (int i = 0; i < 8; i++) begin
      send_rx(vt[i].rx);
      check($sformatf("cmd_vec%0d", i), 32'(state), 32'(vt[i].st));
    end

    // Run with slow UART
    send_rx(8'h02);
    m_clear();
    while (!m_halt) m_step();
    capture_dump(50, 50, -1, -1);
    check_dump("run_dir");
    check("run_dir_pc", got_word(0), 32'h4);
    check("run_dir_cyc", got_word(1), 32'h2);
    check("run_dir_r1", got_word(3), 32'h5);
    check("run_dir_halt", 32'(halt), 32'd1);
    check("run_dir_state", 32'(state), 32'(ST_IDLE));

    // Single step twice
    send_rx(8'h03);
    check("step_enter", 32'(state), 32'(ST_SW));
    check("step_halt_clr", 32'(halt), 32'd0);
    m_clear();
    send_rx(8'h04);
    m_step();
    capture_dump(1, 3, -1, -1);
    check_dump("step1");
    check("step1_pc", got_word(0), 32'h4);
    check("step1_cyc", got_word(1), 32'h1);
    check("step1_halt", 32'(halt), 32'd0);
    check("step1_state", 32'(state), 32'(ST_SW));
    send_rx(8'h04);
    m_step();
    capture_dump(1, 3, -1, -1);
    check_dump("step2");
    check("step2_pc", got_word(0), 32'h4);
    check("step2_cyc", got_word(1), 32'h2);
    check("step2_halt", 32'(halt), 32'd1);
    check("step2_state", 32'(state), 32'(ST_IDLE));

    // Random programs; the last one has no HALT and runs off the end
    for (int it = 0; it < 4; it++) begin
      for (int i = 0; i < 64; i++) prog[i] = rand_instr();
      if (it < 3) prog[$urandom_range(4, 63)] = 32'hFC000000;
      load_prog($sformatf("load_rnd%0d", it));
      send_rx(8'h02);
      m_clear();
      while (!m_halt) m_step();
      capture_dump(1, 4, (it == 0) ? 37 : -1, -1);
      check_dump($sformatf("rnd%0d", it));
      check($sformatf("rnd%0d_halt", it), 32'(halt), 32'd1);
      check($sformatf("rnd%0d_state", it), 32'(state), 32'(ST_IDLE));
    end

    // Freeze in the middle of a load
    for (int i = 0; i < 64; i++) prog[i] = rand_instr();
    prog[60] = 32'hFC000000;
    send_rx(8'h01);
    for (int i = 0; i < 10; i++) begin send_rx(prog_byte(i)); m_im[i] = prog_byte(i); end
    clk_rst = 1'b1;
    send_rx(8'hAA);
    send_rx(8'h55);
    send_rx(8'h3C);
    check("freeze_load_state", 32'(state), 32'(ST_LOAD));
    clk_rst = 1'b0;
    for (int i = 10; i < 256; i++) begin
      send_rx(prog_byte(i));
      m_im[i] = prog_byte(i);
      if (i == 254) check("freeze_load_pending", 32'(state), 32'(ST_LOAD));
    end
    check("freeze_load_done", 32'(state), 32'(ST_IDLE));
    send_rx(8'h02);
    m_clear();
    while (!m_halt) m_step();
    capture_dump(1, 2, -1, 5);
    check_dump("freeze_run");

    // Reset mid-load keeps the bytes already written
    for (int i = 0; i < 64; i++) prog[i] = 32'h0;
    prog[0] = 32'h20010005;
    prog[1] = 32'hFC000000;
    load_prog("load_pre");
    prog[0] = 32'h20020007;
    prog[1] = 32'h2043FFFF;
    send_rx(8'h01);
    for (int i = 0; i < 8; i++) begin send_rx(prog_byte(i)); m_im[i] = prog_byte(i); end
    do_reset();
    check("rst_load_state", 32'(state), 32'(ST_IDLE));
    send_rx(8'h02);
    m_clear();
    while (!m_halt) m_step();
    capture_dump(1, 2, -1, -1);
    check_dump("partial");
    check("partial_pc", got_word(0), 32'h100);
    check("partial_r3", got_word(5), 32'h6);

    // Reset in the middle of a dump
    send_rx(8'h02);
    to = 0;
    while (!tx_start && to < 2000) begin @(negedge clk); to++; end
    check("rst_dump_started", 32'(tx_start), 32'd1);
    do_reset();
    check("rst_dump_state", 32'(state), 32'(ST_IDLE));
    check("rst_dump_halt", 32'(halt), 32'd0);
    check("rst_dump_start", 32'(tx_start), 32'd0);
    check("rst_dump_data", 32'(tx_data), 32'd0);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin @(negedge clk); if (tx_start) cnt++; end
    check("rst_dump_quiet", 32'(cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
